alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Multi-cycle control sequencer for the 8-bit TinyCPU datapath.
- Fetches 1- or 2-byte instructions over a req/ack instruction-memory port and decodes them.
- Drives the ALU opcode, the register-file read/write controls and the PC.
- Holds the registered zero flag used for conditional branches. The ALU and register file stay outside this block.

Parameters:
- PC_W, 8, instruction address width. PC wraps modulo 2^PC_W.
- RA_W, 2, register-file address width (4 registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse. In IDLE it begins execution at PC=0.
- imem_req  out  1  fetch request. Held high until imem_ack.
- imem_addr  out  PC_W  fetch address. Stable while imem_req is high.
- imem_ack  in  1  fetch complete. imem_data is valid in this cycle.
- imem_data  in  8  instruction or immediate byte.
- alu_opcode  out  3  ALU operation select: 000 ADD, 001 SUB, 010 AND, 011 OR.
- alu_zero  in  1  ALU combinational zero output.
- rf_raddr_a  out  RA_W  ALU operand A register (= rd).
- rf_raddr_b  out  RA_W  ALU operand B register (= rs).
- rf_waddr  out  RA_W  write register (= rd).
- rf_we  out  1  register-file write enable (one cycle).
- rf_wsel  out  1  write-data select: 0 = ALU result, 1 = imm_out.
- imm_out  out  8  latched immediate byte.
- z_flag  out  1  registered zero flag.
- busy  out  1  high in any state except IDLE and HALT.
- halted  out  1  high in HALT.
- retire  out  1  one-cycle pulse per completed instruction.

Behaviour:
- Reset:
  - Synchronous, active-high. Every flop is cleared: state=IDLE, PC=0, IR=0, imm=0, z_flag=0.
  - All outputs are 0 in the cycle after rst is sampled high.
  - Reset overrides every in-flight fetch. An imem_ack arriving in or after the reset cycle is ignored.
- Instruction byte IR: [7:5] op, [4:3] rd, [2:1] rs, [0] reserved (ignored).
- Opcodes:
  - 0xx: ALU op (rd = rd op rs), 1 byte.
  - 100 LDI: rd = next byte, 2 bytes.
  - 101 BZ: if z_flag, PC = next byte, 2 bytes.
  - 110 JMP: PC = next byte, 2 bytes.
  - 111 HALT: 1 byte.
- States and transitions:
  - IDLE: start -> FETCH. start is ignored in every other state.
  - FETCH: imem_req=1, imem_addr=PC. On imem_ack: IR<=imem_data, PC<=PC+1, go to DECODE. No ack -> stay, with request and address held.
  - DECODE (1 cycle):
    - ALU op -> EXEC.
    - LDI, BZ, JMP -> FETCH_IMM.
    - HALT -> HALT, with retire=1.
  - FETCH_IMM: same handshake as FETCH. On ack: imm<=imem_data, PC<=PC+1, go to EXEC.
  - EXEC (1 cycle), then retire=1 and go to FETCH:
    - ALU op: rf_we=1, rf_wsel=0, z_flag<=alu_zero.
    - LDI: rf_we=1, rf_wsel=1. z_flag unchanged.
    - BZ: PC<=imm if z_flag=1.
    - JMP: PC<=imm.
  - HALT: terminal. Only rst leaves it.
- Decode outputs are combinational from IR:
  - rf_raddr_a = rf_waddr = IR[4:3].
  - rf_raddr_b = IR[2:1].
  - alu_opcode = IR[7]=0 ? {1'b0, IR[6:5]} : 3'b000.
  - rf_we and retire are registered-state decodes, never combinational on inputs.
- Latency with zero-wait memory (ack in the first req cycle):
  - ALU op: 3 cycles.
  - LDI, BZ, JMP: 4 cycles.
  - Each added memory wait cycle adds one cycle.
- Boundary conditions:
  - PC wraps: 0xFF+1 = 0x00. This also applies to the immediate fetch of an instruction at 0xFF, which reads address 0x00.
  - BZ with z_flag=0 falls through to PC+2.
  - The zero flag written by an ALU op is visible to a BZ that immediately follows.
  - imem_ack while imem_req=0 is ignored.
  - imem_req deasserts in the cycle after ack.

Decomposition:
- Shared package tinycpu_pkg holds:
  - Opcode constants: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI, OP_BZ, OP_JMP, OP_HALT.
  - The state enum.
  - IR field positions.
  - WSEL_ALU / WSEL_IMM.
- The ALU opcode constants in the package are shared with the ALU.
- One natural sub-module: alu_seq_decode. It is purely combinational and maps IR to the op class, the register addresses and alu_opcode.
- The FSM and PC stay in alu_seq.

Test Plan:
- rst held 3 cycles, then released -> all outputs 0, state IDLE. Assert rst mid-FETCH with req high -> imem_req=0 next cycle and the late ack is ignored.
- start, mem = {0x08 (ADD r1,r0), 0xFF}, zero-wait -> rf_we high exactly in cycle 3 with waddr=1, raddr_b=0, alu_opcode=000; retire in the same cycle; then HALT, with halted=1 and busy=0.
- LDI r2,0x5A at 0x00 with 2 wait cycles per fetch -> imem_addr held at 0x00 then at 0x01 while waiting; rf_we with wsel=1 and imm_out=0x5A in cycle 8; z_flag unchanged.
- SUB r1,r1 (alu_zero=1) then BZ 0x40 -> z_flag=1 and the next fetch address is 0x40. Repeat with alu_zero=0 -> the next fetch is 0x03.
- JMP 0xFF at address 0x10; at 0xFF place LDI -> the immediate is fetched from 0x00 (wrap) and the following fetch is at 0x01.
- start pulsed during FETCH and during HALT -> no effect, and the PC sequence is unchanged.

Source files
------------

// File: rtl/tinycpu_pkg.sv
// Shared TinyCPU definitions: opcodes, IR field positions, sequencer states,
// decoded instruction classes and write-data select codes.
package tinycpu_pkg;

  // Opcode field values; the four ALU codes double as the ALU operation select
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_LDI  = 3'b100;
  localparam logic [2:0] OP_BZ   = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Instruction byte layout: [7:5] op, [4:3] rd, [2:1] rs, [0] reserved
  localparam int IR_OP_HI = 7;
  localparam int IR_OP_LO = 5;
  localparam int IR_RD_HI = 4;
  localparam int IR_RD_LO = 3;
  localparam int IR_RS_HI = 2;
  localparam int IR_RS_LO = 1;
  localparam int IR_RSVD  = 0;

  // Register-file write-data select
  localparam logic WSEL_ALU = 1'b0;
  localparam logic WSEL_IMM = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_FETCH_IMM = 3'd3,
    S_EXEC      = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU  = 3'd0,
    CLS_LDI  = 3'd1,
    CLS_BZ   = 3'd2,
    CLS_JMP  = 3'd3,
    CLS_HALT = 3'd4
  } op_class_e;

  // Instructions carrying a second (immediate/target) byte
  function automatic logic needs_imm(input op_class_e cls);
    return (cls == CLS_LDI) || (cls == CLS_BZ) || (cls == CLS_JMP);
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction decoder: IR -> op class, register addresses and
// ALU operation select.
module alu_seq_decode
  import tinycpu_pkg::*;
#(
  parameter int RA_W = 2
) (
  input  logic [7:0]      ir_i,
  output op_class_e       op_class_o,
  output logic [RA_W-1:0] rd_o,
  output logic [RA_W-1:0] rs_o,
  output logic [2:0]      alu_opcode_o
);

  logic [2:0] op_s;
  logic       unused_rsvd_s;

  assign op_s          = ir_i[IR_OP_HI:IR_OP_LO];
  assign rd_o          = RA_W'(ir_i[IR_RD_HI:IR_RD_LO]);
  assign rs_o          = RA_W'(ir_i[IR_RS_HI:IR_RS_LO]);
  // Reserved bit carries no meaning
  assign unused_rsvd_s = ir_i[IR_RSVD];

  // Classify the opcode and derive the ALU select (ADD for non-ALU ops)
  always_comb begin
    op_class_o   = CLS_HALT;
    alu_opcode_o = OP_ADD;
    case (op_s)
      OP_ADD, OP_SUB, OP_AND, OP_OR: op_class_o = CLS_ALU;
      OP_LDI:                        op_class_o = CLS_LDI;
      OP_BZ:                         op_class_o = CLS_BZ;
      OP_JMP:                        op_class_o = CLS_JMP;
      OP_HALT:                       op_class_o = CLS_HALT;
      default:                       op_class_o = CLS_HALT;
    endcase
    if (ir_i[IR_OP_HI] == 1'b0) begin
      alu_opcode_o = {1'b0, ir_i[IR_OP_HI-1:IR_OP_LO]};
    end else begin
      alu_opcode_o = OP_ADD;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// TinyCPU multi-cycle control sequencer: fetches 1/2-byte instructions over a
// req/ack port, drives ALU/register-file controls, owns PC and zero flag.
module alu_seq
  import tinycpu_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int RA_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_data,
  output logic [2:0]      alu_opcode,
  input  logic            alu_zero,
  output logic [RA_W-1:0] rf_raddr_a,
  output logic [RA_W-1:0] rf_raddr_b,
  output logic [RA_W-1:0] rf_waddr,
  output logic            rf_we,
  output logic            rf_wsel,
  output logic [7:0]      imm_out,
  output logic            z_flag,
  output logic            busy,
  output logic            halted,
  output logic            retire
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      imm_q, imm_d;
  logic            z_q, z_d;
  op_class_e       op_class_s;
  logic [RA_W-1:0] rd_s;
  logic [RA_W-1:0] rs_s;

  alu_seq_decode #(.RA_W(RA_W)) u_decode (
    .ir_i         (ir_q),
    .op_class_o   (op_class_s),
    .rd_o         (rd_s),
    .rs_o         (rs_s),
    .alu_opcode_o (alu_opcode)
  );

  assign rf_raddr_a = rd_s;
  assign rf_waddr   = rd_s;
  assign rf_raddr_b = rs_s;
  assign imem_addr  = pc_q;
  assign imm_out    = imm_q;
  assign z_flag     = z_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted     = (state_q == S_HALT);

  // Sequencer state and datapath registers; reset wins over any pending ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= {PC_W{1'b0}};
      ir_q    <= 8'h00;
      imm_q   <= 8'h00;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      z_q     <= z_d;
    end
  end

  // Next-state logic and state-decoded control outputs
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    imm_d    = imm_q;
    z_d      = z_q;
    imem_req = 1'b0;
    rf_we    = 1'b0;
    rf_wsel  = WSEL_ALU;
    retire   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (op_class_s == CLS_ALU) begin
          state_d = S_EXEC;
        end else if (needs_imm(op_class_s)) begin
          state_d = S_FETCH_IMM;
        end else begin
          retire  = 1'b1;
          state_d = S_HALT;
        end
      end
      S_FETCH_IMM: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          imm_d   = imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH_IMM;
        end
      end
      S_EXEC: begin
        retire  = 1'b1;
        state_d = S_FETCH;
        case (op_class_s)
          CLS_ALU: begin
            rf_we = 1'b1;
            z_d   = alu_zero;
          end
          CLS_LDI: begin
            rf_we   = 1'b1;
            rf_wsel = WSEL_IMM;
          end
          CLS_BZ: begin
            if (z_q) begin
              pc_d = PC_W'(imm_q);
            end else begin
              pc_d = pc_q;
            end
          end
          CLS_JMP: pc_d = PC_W'(imm_q);
          default: pc_d = pc_q;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with a wait-state memory model.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_data = 8'h00;
  logic [2:0] alu_opcode;
  logic       alu_zero = 1'b0;
  logic [1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
  logic       rf_we, rf_wsel;
  logic [7:0] imm_out;
  logic       z_flag, busy, halted, retire;

  logic [7:0]  mem [0:255];
  int          waits = 0;
  logic        resp_en = 1'b0;
  logic        force_ack = 1'b0;
  logic [7:0]  force_data = 8'h00;
  int          wait_cnt = 0;
  logic [63:0] fetch_sig;
  int          fetch_n;
  int          retire_n;
  int          n_checks = 0;
  int          n_fail = 0;

  alu_seq #(.PC_W(8), .RA_W(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_opcode(alu_opcode), .alu_zero(alu_zero),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .imm_out(imm_out), .z_flag(z_flag),
    .busy(busy), .halted(halted), .retire(retire)
  );

  always #5 clk = ~clk;

  // Memory responder: acks after 'waits' idle request cycles, or forced ack
  always @(negedge clk) begin
    if (force_ack) begin
      imem_ack  = 1'b1;
      imem_data = force_data;
      wait_cnt  = 0;
    end else if (resp_en && imem_req) begin
      if (wait_cnt >= waits) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
        wait_cnt  = 0;
      end else begin
        imem_ack  = 1'b0;
        wait_cnt  = wait_cnt + 1;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  // Record completed fetch addresses and retire pulses
  always @(posedge clk) begin
    if (rst) begin
      fetch_sig <= 64'h0;
      fetch_n   <= 0;
      retire_n  <= 0;
    end else begin
      if (imem_req && imem_ack) begin
        fetch_sig <= {fetch_sig[55:0], imem_addr};
        fetch_n   <= fetch_n + 1;
      end
      if (retire) retire_n <= retire_n + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
  endtask

  task automatic mem_fill();
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int c;
    c = 0;
    while (!halted && c < 200) begin
      step();
      c++;
    end
    n_checks++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_halt_timeout: halted=%b after %0d cycles, required 1", name, halted, c);
    end
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    resp_en = 1'b0;
    force_ack = 1'b0;
    do_reset();
    outs = {imem_req, imem_addr, alu_opcode, rf_raddr_a, rf_raddr_b, rf_waddr,
            rf_we, rf_wsel, imm_out, z_flag, busy, halted, retire};
    n_checks++;
    if (outs !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 00000000", outs);
    end
    start_pulse();
    step();
    n_checks++;
    if ({imem_req, imem_addr, busy} !== {1'b1, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_prefetch: req=%b addr=%h busy=%b required 1 00 1", imem_req, imem_addr, busy);
    end
    rst = 1'b1;
    force_ack = 1'b1;
    force_data = 8'h08;
    step();
    n_checks++;
    if ({imem_req, busy, rf_raddr_a} !== {1'b0, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_midfetch: req=%b busy=%b raddr_a=%0d required 0 0 0", imem_req, busy, rf_raddr_a);
    end
    step();
    rst = 1'b0;
    step();
    step();
    n_checks++;
    if ({imem_req, busy, rf_raddr_a, retire} !== {1'b0, 1'b0, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_late_ack: req=%b busy=%b raddr_a=%0d retire=%b required 0 0 0 0",
               imem_req, busy, rf_raddr_a, retire);
    end
    force_ack = 1'b0;
    step();
  endtask

  task automatic test_alu_halt();
    mem_fill();
    mem[0] = 8'h08;
    mem[1] = 8'hFF;
    waits = 0;
    resp_en = 1'b1;
    alu_zero = 1'b1;
    do_reset();
    start_pulse();
    for (int c = 1; c <= 6; c++) begin
      n_checks++;
      if ({rf_we, retire, imem_req, busy, halted} !==
          {(c == 3), (c == 3 || c == 5), (c == 1 || c == 4), (c < 6), (c == 6)}) begin
        n_fail++;
        $display("FAIL alu_cycle%0d: we/ret/req/busy/halt=%b%b%b%b%b", c, rf_we, retire, imem_req, busy, halted);
      end
      if (c == 3) begin
        n_checks++;
        if ({rf_waddr, rf_raddr_a, rf_raddr_b, alu_opcode, rf_wsel} !== {2'd1, 2'd1, 2'd0, 3'b000, 1'b0}) begin
          n_fail++;
          $display("FAIL alu_exec_ctrl: waddr=%0d ra=%0d rb=%0d op=%b wsel=%b required 1 1 0 000 0",
                   rf_waddr, rf_raddr_a, rf_raddr_b, alu_opcode, rf_wsel);
        end
      end
      step();
    end
    n_checks++;
    if ({z_flag, fetch_sig, 8'(fetch_n)} !== {1'b1, 64'h0001, 8'd2}) begin
      n_fail++;
      $display("FAIL alu_trace: z=%b sig=%h n=%0d required 1 0001 2", z_flag, fetch_sig, fetch_n);
    end
  endtask

  task automatic test_ldi_wait();
    logic exp_req;
    mem_fill();
    mem[0] = 8'h90;
    mem[1] = 8'h5A;
    waits = 2;
    alu_zero = 1'b1;
    do_reset();
    start_pulse();
    for (int c = 1; c <= 8; c++) begin
      exp_req = (c inside {1, 2, 3, 5, 6, 7});
      n_checks++;
      if ({imem_req, rf_we} !== {exp_req, (c == 8)}) begin
        n_fail++;
        $display("FAIL ldi_cycle%0d: req=%b we=%b required %b %b", c, imem_req, rf_we, exp_req, (c == 8));
      end
      if (exp_req) begin
        n_checks++;
        if (imem_addr !== ((c < 4) ? 8'h00 : 8'h01)) begin
          n_fail++;
          $display("FAIL ldi_addr%0d: got %h required %h", c, imem_addr, (c < 4) ? 8'h00 : 8'h01);
        end
      end
      if (c == 8) begin
        n_checks++;
        if ({rf_wsel, imm_out, rf_waddr, retire, z_flag} !== {1'b1, 8'h5A, 2'd2, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL ldi_exec: wsel=%b imm=%h waddr=%0d ret=%b z=%b required 1 5a 2 1 0",
                   rf_wsel, imm_out, rf_waddr, retire, z_flag);
        end
      end
      step();
    end
    wait_halt("ldi");
    n_checks++;
    if ({z_flag, fetch_sig, 8'(fetch_n)} !== {1'b0, 64'h000102, 8'd3}) begin
      n_fail++;
      $display("FAIL ldi_trace: z=%b sig=%h n=%0d required 0 000102 3", z_flag, fetch_sig, fetch_n);
    end
  endtask

  task automatic test_bz();
    logic [63:0] exp_sig;
    for (int t = 1; t >= 0; t--) begin
      mem_fill();
      mem[0] = 8'h2A;
      mem[1] = 8'hA0;
      mem[2] = 8'h40;
      waits = 0;
      alu_zero = t[0];
      do_reset();
      start_pulse();
      step();
      step();
      n_checks++;
      if ({alu_opcode, rf_we, rf_raddr_a, rf_raddr_b} !== {3'b001, 1'b1, 2'd1, 2'd1}) begin
        n_fail++;
        $display("FAIL bz%0d_sub_exec: op=%b we=%b ra=%0d rb=%0d required 001 1 1 1",
                 t, alu_opcode, rf_we, rf_raddr_a, rf_raddr_b);
      end
      wait_halt("bz");
      exp_sig = (t == 1) ? 64'h0000000000010240 : 64'h0000000000010203;
      n_checks++;
      if ({z_flag, fetch_sig, 8'(fetch_n)} !== {t[0], exp_sig, 8'd4}) begin
        n_fail++;
        $display("FAIL bz%0d_trace: z=%b sig=%h n=%0d required %b %h 4", t, z_flag, fetch_sig, fetch_n, t[0], exp_sig);
      end
    end
  endtask

  task automatic test_jmp_wrap();
    mem_fill();
    mem[8'h00] = 8'hC0;
    mem[8'h01] = 8'h10;
    mem[8'h10] = 8'hC0;
    mem[8'h11] = 8'hFF;
    mem[8'hFF] = 8'h98;
    mem[8'h02] = 8'hFF;
    waits = 1;
    alu_zero = 1'b0;
    do_reset();
    start_pulse();
    wait_halt("jmp");
    n_checks++;
    if ({fetch_sig, 8'(fetch_n)} !== {64'h00011011FF000102, 8'd8}) begin
      n_fail++;
      $display("FAIL jmp_wrap_trace: sig=%h n=%0d required 00011011ff000102 8", fetch_sig, fetch_n);
    end
    n_checks++;
    if ({imm_out, 8'(retire_n)} !== {8'hC0, 8'd5}) begin
      n_fail++;
      $display("FAIL jmp_wrap_imm: imm=%h retires=%0d required c0 5", imm_out, retire_n);
    end
  endtask

  task automatic test_start_ignored();
    mem_fill();
    mem[0] = 8'h08;
    mem[1] = 8'hFF;
    waits = 1;
    do_reset();
    start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_halt("start");
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    n_checks++;
    if ({halted, busy, imem_req, fetch_sig, 8'(fetch_n)} !== {1'b1, 1'b0, 1'b0, 64'h0001, 8'd2}) begin
      n_fail++;
      $display("FAIL start_ignored: halted=%b busy=%b req=%b sig=%h n=%0d required 1 0 0 0001 2",
               halted, busy, imem_req, fetch_sig, fetch_n);
    end
  endtask

  initial begin
    mem_fill();
    test_reset();
    test_alu_halt();
    test_ldi_wait();
    test_bz();
    test_jmp_wrap();
    test_start_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
